// File: rtl/debounce_edge_if.sv
// Signal bundle between the input synchronizer/consumer side and debounce_edge.
// master drives the synchronized level; slave (the debouncer) drives the outputs.
interface debounce_edge_if;
  logic       sig;
  logic       level;
  logic       rise;
  logic       fall;
  logic [7:0] press_count;
  logic       long_press;

  modport master (
    output sig,
    input  level,
    input  rise,
    input  fall,
    input  press_count,
    input  long_press
  );

  modport slave (
    input  sig,
    output level,
    output rise,
    output fall,
    output press_count,
    output long_press
  );
endinterface

// File: rtl/debounce_edge.sv
// Counter-based button debouncer with registered rise/fall pulses and a wrapping press counter.
// Optional long-press detection is built only when LONG_PRESS_EN is defined.
module debounce_edge #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 50000000
) (
  input  logic           clk,
  input  logic           rst,
  debounce_edge_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 1) begin : g_param_err
    $error("debounce_edge: DEBOUNCE_CYCLES must be >= 2 and LONG_CYCLES >= 1");
  end

  typedef enum logic [1:0] {SLow, SRise, SHigh, SFall} state_e;

  state_e           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             level_d, level_q;
  logic             rise_d, rise_q;
  logic             fall_d, fall_q;
  logic [7:0]       press_count_d, press_count_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    level_d       = level_q;
    rise_d        = 1'b0;
    fall_d        = 1'b0;
    press_count_d = press_count_q;
    unique case (state_q)
      SLow: begin
        if (bus.sig) begin
          state_d = SRise;
          cnt_d   = CNT_W'(1);
        end
      end
      SRise: begin
        if (!bus.sig) begin
          state_d = SLow;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d       = SHigh;
          cnt_d         = '0;
          level_d       = 1'b1;
          rise_d        = 1'b1;
          press_count_d = press_count_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SHigh: begin
        if (!bus.sig) begin
          state_d = SFall;
          cnt_d   = CNT_W'(1);
        end
      end
      SFall: begin
        // Bounce back to high keeps the level and any hold progress.
        if (bus.sig) begin
          state_d = SHigh;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = SLow;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = SLow;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SLow;
      cnt_q         <= '0;
      level_q       <= 1'b0;
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
      press_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      level_q       <= level_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
      press_count_q <= press_count_d;
    end
  end

  assign bus.level       = level_q;
  assign bus.rise        = rise_q;
  assign bus.fall        = fall_q;
  assign bus.press_count = press_count_q;

`ifdef LONG_PRESS_EN
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HoldMax = HOLD_W'(LONG_CYCLES);

  logic [HOLD_W-1:0] hold_cnt_d, hold_cnt_q;
  logic              long_press_d, long_press_q;

  // Saturating at HoldMax guarantees a single long_press per accepted press.
  always_comb begin
    hold_cnt_d   = hold_cnt_q;
    long_press_d = 1'b0;
    if (rise_d || fall_d) begin
      hold_cnt_d = '0;
    end else if (state_q == SHigh && hold_cnt_q != HoldMax) begin
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      if (hold_cnt_q == HoldMax - HOLD_W'(1)) begin
        long_press_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q   <= '0;
      long_press_q <= 1'b0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      long_press_q <= long_press_d;
    end
  end

  assign bus.long_press = long_press_q;
`else
  assign bus.long_press = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_edge.sv
// Scoreboard bench for debounce_edge: a run-length reference model predicts outputs per edge,
// a separate monitor pops and compares them after every clock edge.
module tb_debounce_edge;
  localparam int unsigned DC = 4;
  localparam int unsigned LC = 10;
`ifdef LONG_PRESS_EN
  localparam bit LongEn = 1'b1;
`else
  localparam bit LongEn = 1'b0;
`endif

  typedef struct {
    bit level;
    bit rise;
    bit fall;
    int pc;
    bit lp;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  debounce_edge_if bus ();

  debounce_edge #(
    .DEBOUNCE_CYCLES(DC),
    .LONG_CYCLES    (LC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: level flips after DC consecutive samples differing from it.
  bit m_level = 1'b0;
  int m_run   = 0;
  int m_held  = 0;
  int m_pc    = 0;
  int m_rises = 0;
  int obs_rises = 0;
  int obs_falls = 0;
  int obs_longs = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic drive(input bit r, input bit s);
    exp_t e;
    @(negedge clk);
    rst     = r;
    bus.sig = s;
    e = '{level: 1'b0, rise: 1'b0, fall: 1'b0, pc: 0, lp: 1'b0};
    if (r) begin
      m_level = 1'b0;
      m_run   = 0;
      m_held  = 0;
      m_pc    = 0;
    end else begin
      if (m_level && m_run == 0) begin
        m_held++;
        if (m_held == LC && LongEn) e.lp = 1'b1;
      end
      if (s != m_level) begin
        m_run++;
        if (m_run == DC) begin
          m_level = s;
          m_run   = 0;
          m_held  = 0;
          if (s) begin
            e.rise = 1'b1;
            m_pc   = (m_pc + 1) % 256;
            m_rises++;
          end else begin
            e.fall = 1'b1;
          end
        end
      end else begin
        m_run = 0;
      end
      e.level = m_level;
      e.pc    = m_pc;
    end
    exp_q.push_back(e);
  endtask

  task automatic drive_n(input bit s, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, s);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("level", bus.level, e.level);
        chk("rise", bus.rise, e.rise);
        chk("fall", bus.fall, e.fall);
        chk("press_count", bus.press_count, e.pc);
        chk("long_press", bus.long_press, e.lp);
        chk("no_dual_pulse", bus.rise & bus.fall, 0);
        if (bus.rise === 1'b1) obs_rises++;
        if (bus.fall === 1'b1) obs_falls++;
        if (bus.long_press === 1'b1) obs_longs++;
      end
    end
  end

  initial begin
    int base_r, base_f, base_pc, base_l, len;
    bit s;
    rst     = 1'b1;
    bus.sig = 1'b0;
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b0);

    // Glitch rejection, clean press, bouncy release
    drive_n(1'b1, 3);
    drive_n(1'b0, 3);
    drive_n(1'b1, 6);
    drive_n(1'b0, 2);
    drive_n(1'b1, 1);
    drive_n(1'b0, 6);

    // Reset while in rise-debounce with sig held high
    drive_n(1'b1, 2);
    drive(1'b1, 1'b1);
    drive_n(1'b1, 6);
    drive_n(1'b0, 6);

    // Long hold, then a short hold
    drain();
    base_l = obs_longs;
    drive_n(1'b1, 20);
    drive_n(1'b0, 6);
    drain();
    chk("long_hold_pulses", obs_longs - base_l, LongEn ? 1 : 0);
    base_l = obs_longs;
    drive_n(1'b1, 9);
    drive_n(1'b0, 6);
    drain();
    chk("short_hold_pulses", obs_longs - base_l, 0);

    // Counter wrap
    base_r  = obs_rises;
    base_f  = obs_falls;
    base_pc = m_pc;
    for (int i = 0; i < 256; i++) begin
      drive_n(1'b1, 5);
      drive_n(1'b0, 5);
    end
    drain();
    chk("wrap_rises", obs_rises - base_r, 256);
    chk("wrap_falls", obs_falls - base_f, 256);
    chk("wrap_press_count", bus.press_count, base_pc[7:0]);

    // Randomized bouncy traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      s   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      if ($urandom_range(0, 60) == 0) drive(1'b1, s);
      drive_n(s, len);
    end
    drive_n(1'b0, 6);
    drain();
    chk("total_rises", obs_rises, m_rises);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
